// File: rtl/divisor_signado.sv
// divisor_signado
// Multicycle signed integer divider for the MIPS execute stage. Produces the
// LO (quotient) and HI (remainder) results of DIV using a restoring
// shift-and-subtract loop on operand magnitudes, followed by a sign fix-up.
// A start/busy/valid handshake lets pipeline control stall while it runs.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_start        division request, only sampled while idle
//   i_data_A       dividend (two's complement)
//   i_data_B       divisor (two's complement)
//   o_quotient     signed quotient (LO), truncated toward zero
//   o_remainder    signed remainder (HI), carries the dividend's sign
//   o_busy         high from the accepted start until o_valid
//   o_valid        one-cycle pulse when the results are updated
//   o_div_by_zero  high with the results when the divisor was zero
module divisor_signado #(
    parameter int INPUT_OUTPUT_LENGTH = 32
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [INPUT_OUTPUT_LENGTH-1:0] i_data_A,
    input  logic [INPUT_OUTPUT_LENGTH-1:0] i_data_B,
    output logic [INPUT_OUTPUT_LENGTH-1:0] o_quotient,
    output logic [INPUT_OUTPUT_LENGTH-1:0] o_remainder,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic                           o_div_by_zero
);

    localparam int N  = INPUT_OUTPUT_LENGTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor_mag;
    logic [N-1:0]  rem;
    logic [N-1:0]  quo;
    logic [CW-1:0] count;
    logic          sign_q;
    logic          sign_r;
    logic          zero_div;

    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [N:0]    trial;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  quo_fixed;
    logic [N-1:0]  rem_fixed;

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly 2^(N-1), so no extra bit is required.
    always_comb begin
        mag_a = i_data_A[N-1] ? -i_data_A : i_data_A;
        mag_b = i_data_B[N-1] ? -i_data_B : i_data_B;
    end

    // One restoring iteration. The trial subtraction is one bit wider than
    // the operands so its MSB acts as the borrow: a clear MSB means the
    // shifted remainder was large enough and the quotient bit is one.
    always_comb begin
        trial    = {rem, quo[N-1]} - {1'b0, divisor_mag};
        rem_next = trial[N] ? {rem[N-2:0], quo[N-1]} : trial[N-1:0];
        quo_next = {quo[N-2:0], ~trial[N]};
    end

    // Sign fix-up applied to the unsigned results in the FIX state.
    always_comb begin
        quo_fixed = sign_q ? -quo : quo;
        rem_fixed = sign_r ? -rem : rem;
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. CALC leaves after the iteration that sees the
    // counter at 1, so exactly N iterations run before FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. The quotient register starts with
    // |A| and is shifted into the remainder one bit per CALC cycle. A zero
    // divisor still runs the full loop; its results are overridden in FIX.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            dividend      <= '0;
            divisor_mag   <= '0;
            rem           <= '0;
            quo           <= '0;
            count         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            zero_div      <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_valid       <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        dividend    <= i_data_A;
                        divisor_mag <= mag_b;
                        quo         <= mag_a;
                        rem         <= '0;
                        count       <= CW'(N);
                        sign_q      <= i_data_A[N-1] ^ i_data_B[N-1];
                        sign_r      <= i_data_A[N-1];
                        zero_div    <= (i_data_B == '0);
                        o_busy      <= 1'b1;
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - CW'(1);
                end
                FIX: begin
                    o_quotient    <= zero_div ? '1 : quo_fixed;
                    o_remainder   <= zero_div ? dividend : rem_fixed;
                    o_div_by_zero <= zero_div;
                    o_valid       <= 1'b1;
                    o_busy        <= 1'b0;
                end
                default: begin
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_signado.sv
// tb_divisor_signado
// Self-checking bench for divisor_signado. Expected results come from a
// behavioural model using 64-bit integer arithmetic on operand magnitudes.
module tb_divisor_signado;

    localparam int N      = 32;
    localparam int PERIOD = 10;

    logic         i_clock = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [N-1:0] i_data_A;
    logic [N-1:0] i_data_B;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;
    logic         o_busy;
    logic         o_valid;
    logic         o_div_by_zero;

    int     compare_count = 0;
    int     fail_count    = 0;
    longint t_start;
    longint t_valid;

    divisor_signado #(
        .INPUT_OUTPUT_LENGTH(N)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_data_A     (i_data_A),
        .i_data_B     (i_data_B),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_div_by_zero(o_div_by_zero)
    );

    // Free-running clock.
    always #(PERIOD / 2) i_clock = ~i_clock;

    // Reference division: magnitudes divided in 64 bits, signs applied after.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dbz);
        longint sa, sb, ma, mb, qm, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            qm  = ma / mb;
            rm  = ma % mb;
            q   = N'(((sa < 0) != (sb < 0)) ? -qm : qm);
            r   = N'((sa < 0) ? -rm : rm);
            dbz = 1'b0;
        end
    endfunction

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives a start request that the next rising edge samples, then
    // scrambles the operand inputs to expose any re-sampling.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        i_data_A = a;
        i_data_B = b;
        i_start  = 1'b1;
        @(posedge i_clock);
        t_start = $time;
        #1;
        checkOutput("busy_after_start", {63'd0, o_busy}, 64'd1);
        i_start  = 1'b0;
        i_data_A = $urandom;
        i_data_B = $urandom;
    endtask

    // Waits (bounded) for o_valid, checking busy stays high meanwhile.
    task automatic waitResult(output bit got);
        bit busy_dropped;
        busy_dropped = 1'b0;
        got          = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge i_clock);
            #1;
            if (o_valid) begin
                got     = 1'b1;
                t_valid = $time - 1;
                break;
            end
            if (!o_busy) busy_dropped = 1'b1;
        end
        checkOutput("busy_held", {63'd0, busy_dropped}, 64'd0);
        if (!got) checkOutput("valid_timeout", 64'd0, 64'd1);
    endtask

    // Waits for the result of a started division and checks it.
    task automatic checkResult(input string tag, input logic [N-1:0] a,
                               input logic [N-1:0] b, input bit check_pulse);
        logic [N-1:0] eq, er;
        logic         edz;
        bit           got;
        ref_div(a, b, eq, er, edz);
        waitResult(got);
        if (got) begin
            checkOutput({tag, "_latency"}, 64'((t_valid - t_start) / PERIOD), 64'd33);
            checkOutput({tag, "_q"}, 64'(o_quotient), 64'(eq));
            checkOutput({tag, "_r"}, 64'(o_remainder), 64'(er));
            checkOutput({tag, "_dbz"}, {63'd0, o_div_by_zero}, {63'd0, edz});
            checkOutput({tag, "_busy_low"}, {63'd0, o_busy}, 64'd0);
            if (check_pulse) begin
                @(posedge i_clock);
                #1;
                checkOutput({tag, "_valid_pulse"}, {63'd0, o_valid}, 64'd0);
                checkOutput({tag, "_q_hold"}, 64'(o_quotient), 64'(eq));
            end
        end
    endtask

    task automatic runDivision(input string tag, input logic [N-1:0] a,
                               input logic [N-1:0] b);
        @(negedge i_clock);
        applyStimulus(a, b);
        checkResult(tag, a, b, 1'b1);
    endtask

    initial begin
        longint       first_valid;
        bit           seen;
        logic [N-1:0] ra, rb;

        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_data_A = '0;
        i_data_B = '0;
        #2;
        checkOutput("reset_q", 64'(o_quotient), 64'd0);
        checkOutput("reset_r", 64'(o_remainder), 64'd0);
        checkOutput("reset_busy", {63'd0, o_busy}, 64'd0);
        checkOutput("reset_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("reset_dbz", {63'd0, o_div_by_zero}, 64'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;

        // Basic and sign combinations.
        runDivision("pos_pos", 32'd7, 32'd2);
        runDivision("neg_pos", -32'sd7, 32'd2);
        runDivision("pos_neg", 32'd7, -32'sd2);
        runDivision("neg_neg", -32'sd7, -32'sd2);

        // Edge operands.
        runDivision("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        runDivision("min_by_1", 32'h8000_0000, 32'd1);
        runDivision("min_by_min", 32'h8000_0000, 32'h8000_0000);

        // Divide by zero, then recovery.
        runDivision("div_zero", 32'd5, 32'd0);
        runDivision("after_zero", 32'd9, 32'd3);

        // Start during CALC must be ignored.
        @(negedge i_clock);
        applyStimulus(32'd100, 32'd7);
        repeat (4) @(negedge i_clock);
        i_data_A = 32'd1;
        i_data_B = 32'd1;
        i_start  = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        checkResult("ignored_start", 32'd100, 32'd7, 1'b1);

        // Start in the valid cycle is accepted: back-to-back spacing N+2.
        @(negedge i_clock);
        applyStimulus(32'd50, 32'd4);
        checkResult("b2b_first", 32'd50, 32'd4, 1'b0);
        first_valid = t_valid;
        applyStimulus(-32'sd9, 32'd4);
        checkResult("b2b_second", -32'sd9, 32'd4, 1'b1);
        checkOutput("b2b_spacing", 64'((t_valid - first_valid) / PERIOD), 64'd34);

        // Asynchronous abort mid-operation.
        @(negedge i_clock);
        applyStimulus(32'd100, 32'd7);
        repeat (9) @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        #1;
        checkOutput("abort_q", 64'(o_quotient), 64'd0);
        checkOutput("abort_r", 64'(o_remainder), 64'd0);
        checkOutput("abort_busy", {63'd0, o_busy}, 64'd0);
        checkOutput("abort_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("abort_dbz", {63'd0, o_div_by_zero}, 64'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clock);
            #1;
            if (o_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", {63'd0, seen}, 64'd0);
        runDivision("after_abort", 32'd20, 32'd6);

        // Randomized operands with a bias toward interesting values.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = N'($urandom_range(0, 200)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = N'($urandom_range(1, 15)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
                default: rb = $urandom;
            endcase
            runDivision($sformatf("rand%0d", i), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", compare_count, fail_count);
        $finish;
    end

endmodule
